// File: rtl/kuz_pkg.sv
// rtl/kuz_pkg.sv - shared Kuznyechik types and scheduler state encoding
package kuz_pkg;

  typedef logic [127:0] block_t;
  typedef logic [3:0]   key_idx_t;

  localparam int KUZ_NROUNDS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/kuz_dec_sched_if.sv
// rtl/kuz_dec_sched_if.sv - block, key-store and LS-inverse unit signals of the decrypt scheduler
interface kuz_dec_sched_if;
  import kuz_pkg::*;

  logic     in_valid;
  logic     in_ready;
  block_t   din;
  key_idx_t key_idx;
  block_t   key_data;
  logic     ls_valid;
  block_t   ls_din;
  logic     ls_ready;
  block_t   ls_dout;
  logic     out_valid;
  block_t   dout;
  logic     busy;

  modport master (
    input  in_valid, din, key_data, ls_ready, ls_dout,
    output in_ready, key_idx, ls_valid, ls_din, out_valid, dout, busy
  );

  modport slave (
    output in_valid, din, key_data, ls_ready, ls_dout,
    input  in_ready, key_idx, ls_valid, ls_din, out_valid, dout, busy
  );

endinterface

// File: rtl/kuz_dec_sched.sv
// rtl/kuz_dec_sched.sv - round scheduler driving one shared LS-inverse unit for block decryption
module kuz_dec_sched
  import kuz_pkg::*;
#(
  parameter int NROUNDS = KUZ_NROUNDS,
  parameter int KEY_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  kuz_dec_sched_if.master  bus
);

  localparam key_idx_t KEY_FIRST = key_idx_t'(NROUNDS);

  if (KEY_LAT != 1) begin : g_key_lat_check
    $error("kuz_dec_sched: only KEY_LAT == 1 is supported");
  end
  if (NROUNDS < 1 || NROUNDS > 15) begin : g_nrounds_check
    $error("kuz_dec_sched: NROUNDS must be in 1..15");
  end

  state_t   state;
  block_t   data_r;
  key_idx_t key_idx_r;
  logic     in_ready_r;
  logic     busy_r;
  logic     ls_valid_r;
  logic     out_valid_r;
  block_t   dout_r;

  // key_idx only moves at CALL exit and at block completion, so key_data
  // is settled long before WAIT consumes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      data_r      <= '0;
      key_idx_r   <= KEY_FIRST;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      ls_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      dout_r      <= '0;
    end else begin
      ls_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_r     <= bus.din;
            ls_valid_r <= 1'b1;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= CALL;
          end
        end
        CALL: begin
          key_idx_r <= key_idx_r - key_idx_t'(1);
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.ls_ready) begin
            if (key_idx_r != '0) begin
              data_r     <= bus.ls_dout;
              ls_valid_r <= 1'b1;
              state      <= CALL;
            end else begin
              dout_r      <= bus.ls_dout ^ bus.key_data;
              out_valid_r <= 1'b1;
              key_idx_r   <= KEY_FIRST;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          key_idx_r  <= KEY_FIRST;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.key_idx   = key_idx_r;
  assign bus.ls_valid  = ls_valid_r;
  assign bus.ls_din    = (state == CALL) ? (data_r ^ bus.key_data) : '0;
  assign bus.out_valid = out_valid_r;
  assign bus.dout      = dout_r;

endmodule

// File: tb/tb_kuz_dec_sched.sv
// tb/tb_kuz_dec_sched.sv - directed bench for kuz_dec_sched with LS-inverse stub and key store model
module tb_kuz_dec_sched;
  import kuz_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kuz_dec_sched_if bus();

  kuz_dec_sched #(.NROUNDS(9), .KEY_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pi_dec [256] = '{
    252,238,221,17,207,110,49,22,251,196,250,218,35,197,4,77,
    233,119,240,219,147,46,153,186,23,54,241,187,20,205,95,193,
    249,24,101,90,226,92,239,33,129,28,60,66,139,1,142,79,
    5,132,2,174,227,106,143,160,6,11,237,152,127,212,211,31,
    235,52,44,81,234,200,72,171,242,42,104,162,253,58,206,204,
    181,112,14,86,8,12,118,18,191,114,19,71,156,183,93,135,
    21,161,150,41,16,123,154,199,243,145,120,111,157,158,178,177,
    50,117,25,61,255,53,138,126,109,84,198,128,195,189,13,87,
    223,245,36,169,62,168,67,201,215,121,214,246,124,34,185,3,
    224,15,236,222,122,148,176,188,220,232,40,80,78,51,10,74,
    167,151,96,115,30,0,98,68,26,184,56,130,100,159,38,65,
    173,69,70,146,39,94,85,47,140,163,165,125,105,213,149,59,
    7,88,179,64,134,172,29,247,48,55,107,228,136,217,231,137,
    225,27,131,73,76,63,248,254,141,83,170,144,202,216,133,97,
    32,113,103,164,45,43,9,91,203,155,37,208,190,229,108,82,
    89,166,116,210,230,244,180,192,209,102,175,194,57,75,99,182};
  int l_dec [16] = '{1,148,32,133,16,194,192,1,251,1,192,194,16,133,32,148};
  logic [7:0] pi_tab  [256];
  logic [7:0] pi_inv  [256];
  logic [7:0] l_coef  [16];

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ((a << 1) ^ 8'hC3) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] lfun(block_t v);
    logic [7:0] t = 8'h00;
    for (int j = 0; j < 16; j++) t = t ^ gf_mul(v[8*j +: 8], l_coef[j]);
    return t;
  endfunction

  function automatic block_t l_fwd(block_t v);
    for (int i = 0; i < 16; i++) v = {lfun(v), v[127:8]};
    return v;
  endfunction

  function automatic block_t l_inv(block_t v);
    for (int i = 0; i < 16; i++) v = {v[119:0], lfun({v[119:0], v[127:120]})};
    return v;
  endfunction

  function automatic block_t s_fwd(block_t v);
    for (int j = 0; j < 16; j++) v[8*j +: 8] = pi_tab[v[8*j +: 8]];
    return v;
  endfunction

  function automatic block_t s_inv(block_t v);
    for (int j = 0; j < 16; j++) v[8*j +: 8] = pi_inv[v[8*j +: 8]];
    return v;
  endfunction

  block_t key_mem [16];
  always @(posedge clk) bus.key_data <= key_mem[bus.key_idx];

  // LS-inverse unit stub: fixed 6-cycle or random 3..20 latency, optional spurious strobes while idle
  bit     real_ls = 1'b0;
  bit     rand_lat = 1'b0;
  bit     spur_en = 1'b0;
  bit     pend = 1'b0;
  int     due = 0;
  block_t pdata;

  always begin
    @(posedge clk);
    #1;
    bus.ls_ready = 1'b0;
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend && cyc >= due) begin
        bus.ls_ready = 1'b1;
        bus.ls_dout  = real_ls ? s_inv(l_inv(pdata)) : pdata;
        pend = 1'b0;
      end else if (spur_en && !pend && !bus.busy && $urandom_range(3, 0) == 0) begin
        bus.ls_ready = 1'b1;
        bus.ls_dout  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (bus.ls_valid) begin
        pend  = 1'b1;
        pdata = bus.ls_din;
        due   = cyc + (rand_lat ? int'($urandom_range(20, 3)) : 6);
      end
    end
  end

  int       acc_cycle, acc_count, ov_cycle, ov_count, lsv_n, kchg_n;
  int       lsv_cyc [32];
  key_idx_t kchg [32];
  key_idx_t last_kidx = 4'd9;
  block_t   ov_data;

  always @(negedge clk) begin
    if (reset_n && bus.in_valid && bus.in_ready) begin
      acc_cycle = cyc;
      acc_count++;
    end
    if (bus.ls_valid) begin
      if (lsv_n < 32) lsv_cyc[lsv_n] = cyc;
      lsv_n++;
    end
    if (bus.out_valid) begin
      ov_cycle = cyc;
      ov_data  = bus.dout;
      ov_count++;
    end
    if (bus.key_idx !== last_kidx) begin
      if (kchg_n < 32) kchg[kchg_n] = bus.key_idx;
      kchg_n++;
      last_kidx = bus.key_idx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_count = 0; ov_count = 0; lsv_n = 0; kchg_n = 0;
    last_kidx = bus.key_idx;
  endtask

  task automatic offer(input block_t d, output bit ok);
    ok = 1'b0;
    bus.din = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %0b want 1", tag, bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %0b want 0", tag, bus.busy); end
    checks++; if (bus.key_idx !== 4'd9) begin errors++; $display("FAIL %s key_idx: got %0d want 9", tag, bus.key_idx); end
    checks++; if (bus.ls_valid !== 1'b0) begin errors++; $display("FAIL %s ls_valid: got %0b want 0", tag, bus.ls_valid); end
    checks++; if (bus.ls_din !== 128'h0) begin errors++; $display("FAIL %s ls_din: got %h want 0", tag, bus.ls_din); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %0b want 0", tag, bus.out_valid); end
    checks++; if (bus.dout !== 128'h0) begin errors++; $display("FAIL %s dout: got %h want 0", tag, bus.dout); end
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_identity_zero();
    bit ok;
    int bad;
    key_idx_t exp_k;
    for (int i = 0; i < 16; i++) key_mem[i] = 128'(i);
    tick(2);
    clear_mon();
    offer(128'h0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL id0 accept: got timeout want accept"); end
    wait_out(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL id0 out_valid: got timeout want strobe"); end
    checks++; if (ov_data !== 128'h1) begin errors++; $display("FAIL id0 dout: got %h want 1", ov_data); end
    checks++; if (ov_cycle - acc_cycle != 64) begin errors++; $display("FAIL id0 latency: got %0d want 64", ov_cycle - acc_cycle); end
    checks++; if (lsv_n != 9) begin errors++; $display("FAIL id0 ls_valid count: got %0d want 9", lsv_n); end
    bad = 0;
    for (int k = 0; k < 9 && k < lsv_n; k++) if (lsv_cyc[k] - acc_cycle != 1 + 7*k) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL id0 call timing: got %0d misplaced want 0", bad); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      exp_k = (k == 9) ? 4'd9 : 4'(8 - k);
      if (k >= kchg_n || kchg[k] !== exp_k) bad++;
    end
    checks++; if (bad != 0 || kchg_n != 10) begin errors++; $display("FAIL id0 key_idx seq: got %0d changes %0d wrong want 10 changes 0 wrong", kchg_n, bad); end
    tick(5);
    checks++; if (ov_count != 1) begin errors++; $display("FAIL id0 out_valid count: got %0d want 1", ov_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int a1, a2;
    block_t d2 = 128'h0123456789abcdef_fedcba9876543210;
    clear_mon();
    offer({128{1'b1}}, ok);
    a1 = acc_cycle;
    offer(d2, ok);
    a2 = acc_cycle;
    checks++; if (!ok || a2 - a1 != 64) begin errors++; $display("FAIL b2b second accept: got cycle %0d want 64", a2 - a1); end
    checks++; if (ov_data !== {{127{1'b1}}, 1'b0} || ov_cycle - a1 != 64) begin errors++; $display("FAIL b2b first: got %h at %0d want fff..fe at 64", ov_data, ov_cycle - a1); end
    wait_out(200, ok);
    checks++; if (!ok || ov_data !== (d2 ^ 128'h1)) begin errors++; $display("FAIL b2b second dout: got %h want %h", ov_data, d2 ^ 128'h1); end
    checks++; if (ov_cycle - a1 != 128) begin errors++; $display("FAIL b2b second latency: got %0d want 128", ov_cycle - a1); end
  endtask

  task automatic test_random_latency();
    bit ok;
    block_t d3 = 128'hdeadbeef_00112233_cafef00d_55aa55aa;
    block_t prev = 128'h0123456789abcdef_fedcba9876543210 ^ 128'h1;
    rand_lat = 1'b1;
    spur_en  = 1'b1;
    clear_mon();
    tick(20);
    checks++; if (ov_count != 0) begin errors++; $display("FAIL rnd spurious out_valid: got %0d want 0", ov_count); end
    checks++; if (bus.dout !== prev) begin errors++; $display("FAIL rnd held dout: got %h want %h", bus.dout, prev); end
    offer(d3, ok);
    wait_out(600, ok);
    checks++; if (!ok || ov_data !== (d3 ^ 128'h1)) begin errors++; $display("FAIL rnd dout: got %h want %h", ov_data, d3 ^ 128'h1); end
    tick(30);
    checks++; if (ov_count != 1 || lsv_n != 9) begin errors++; $display("FAIL rnd counts: got ov=%0d lsv=%0d want ov=1 lsv=9", ov_count, lsv_n); end
    rand_lat = 1'b0;
    spur_en  = 1'b0;
    tick(25);
  endtask

  task automatic test_reset_mid();
    bit ok;
    block_t d5 = 128'h55555555_aaaaaaaa_12345678_9abcdef0;
    clear_mon();
    offer(128'h77, ok);
    tick(29);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    tick(2);
    reset_n = 1'b1;
    tick(50);
    checks++; if (ov_count != 0) begin errors++; $display("FAIL midrst out_valid: got %0d want 0", ov_count); end
    offer(d5, ok);
    wait_out(200, ok);
    checks++; if (!ok || ov_data !== (d5 ^ 128'h1)) begin errors++; $display("FAIL midrst next dout: got %h want %h", ov_data, d5 ^ 128'h1); end
    tick(2);
  endtask

  task automatic test_real_unit();
    bit ok;
    block_t rk [10];
    block_t a1, a0, t;
    rk[0] = 128'h8899aabbccddeeff0011223344556677;
    rk[1] = 128'hfedcba98765432100123456789abcdef;
    for (int i = 0; i < 4; i++) begin
      a1 = rk[2*i];
      a0 = rk[2*i+1];
      for (int j = 1; j <= 8; j++) begin
        t  = l_fwd(s_fwd(a1 ^ l_fwd(128'(8*i + j)))) ^ a0;
        a0 = a1;
        a1 = t;
      end
      rk[2*i+2] = a1;
      rk[2*i+3] = a0;
    end
    for (int i = 0; i < 10; i++) key_mem[i] = rk[i];
    real_ls = 1'b1;
    tick(2);
    clear_mon();
    offer(128'h7f679d90bebc24305a468d42b9d4edcd, ok);
    wait_out(200, ok);
    checks++; if (!ok || ov_data !== 128'h1122334455667700ffeeddccbbaa9988) begin errors++; $display("FAIL gost dout: got %h want 1122334455667700ffeeddccbbaa9988", ov_data); end
    checks++; if (ov_cycle - acc_cycle != 64) begin errors++; $display("FAIL gost latency: got %0d want 64", ov_cycle - acc_cycle); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pi_tab[i] = 8'(pi_dec[i]);
    for (int i = 0; i < 256; i++) pi_inv[pi_tab[i]] = 8'(i);
    for (int j = 0; j < 16; j++) l_coef[j] = 8'(l_dec[j]);
    for (int i = 0; i < 16; i++) key_mem[i] = '0;
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.ls_ready = 1'b0;
    bus.ls_dout  = '0;
    bus.key_data = '0;
    test_reset();
    test_identity_zero();
    test_back_to_back();
    test_random_latency();
    test_reset_mid();
    test_real_unit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kuz_dec_sched.md
# kuz_dec_sched

Round scheduler for Kuznyechik (GOST R 34.12-2015) block decryption. It owns one shared inverse-LS table unit (valid/pre_ready/ready handshake, 128-bit data) and one synchronous round-key store. For each accepted ciphertext block it runs the 9-round inverse pipeline through that unit, XORs in round keys, and emits the plaintext. It sits between the decryption key-schedule storage and the top-level cipher core.

## Interface
Parameters:
- NROUNDS, 9: number of inverse-LS passes. Key indices NROUNDS down to 0 are used.
- KEY_LAT, 1: round-key read latency in cycles. Only 1 is supported; elaboration asserts on any other value.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted when in_valid && in_ready
- din  in  128  ciphertext block
- key_idx  out  4  round-key index to key store
- key_data  in  128  key store output; valid 1 cycle after key_idx is stable
- ls_valid  out  1  one-cycle start pulse to the LS-inverse unit
- ls_din  out  128  LS-inverse unit operand
- ls_ready  in  1  one-cycle result strobe from the unit
- ls_dout  in  128  unit result; valid while ls_ready is high
- out_valid  out  1  one-cycle plaintext strobe
- dout  out  128  plaintext; held until the next out_valid
- busy  out  1  high in any state other than IDLE

## Operation
- State data_r [127:0] and FSM states: IDLE, CALL, WAIT.
- IDLE:
  - in_ready=1 and key_idx=NROUNDS, so key_data is already valid.
  - On accept: data_r←din, go to CALL.
- CALL (exactly 1 cycle):
  - ls_valid=1, ls_din=data_r^key_data.
  - At the clock edge: key_idx←key_idx−1, go to WAIT.
- WAIT:
  - ls_valid=0. Wait for ls_ready; the number of wait cycles is not assumed.
  - On ls_ready with key_idx≠0: data_r←ls_dout, go to CALL.
  - On ls_ready with key_idx==0: dout←ls_dout^key_data, out_valid←1 for one cycle, key_idx←NROUNDS, go to IDLE.
- Resulting function: x←LSinv(x^K[i]) for i=9..1, then P=x^K[0].
- ls_pre_ready is not used.
- ls_ready received in IDLE or CALL is ignored and raises no error.
- ls_din is 0 in every state except CALL.
- in_valid is ignored while busy. There is no input buffering; upstream must hold the block until in_ready.

## Timing
- Reset values: in_ready=1, busy=0, key_idx=NROUNDS, ls_valid=0, ls_din=0, out_valid=0, dout=0, data_r=0, state=IDLE.
- Reset mid-operation aborts the block with no output. The LS unit shares reset_n, so no stale ls_ready can arrive after reset.
- With the LS unit's 6-cycle latency (ls_valid at t, ls_ready at t+6), each round takes 7 cycles.
- Accept at cycle 0:
  - Round k CALL is at cycle 1+7(k−1).
  - 9th ls_ready is at cycle 63.
  - out_valid is at cycle 64.
- in_ready is high again at cycle 64. A new block accepted at 64 has its first CALL at 65, giving a throughput of 1 block per 64 cycles.
- key_idx changes only at CALL exit and DONE, so key_data is stable ≥5 cycles before use.
- If ls_ready and in_valid are high in the same WAIT cycle, in_valid is ignored.

## Structure
- Shared package kuz_pkg:
  - block_t (logic [127:0])
  - key_idx_t (logic [3:0])
  - KUZ_NROUNDS=9
  - state enum (IDLE, CALL, WAIT)
- No sub-module. The LS-inverse unit and key store are instantiated beside this block in the decryption core.

## Test plan
- Identity LS stub (6-cycle latency) with K[i]=128'(i) and din=128'h0 → dout=128'h1 at cycle 64 after accept. Also check exactly 9 ls_valid pulses and the key_idx sequence 9,8,…,1,0.
- Same stub with din=128'hFFFF…FF → dout=128'hFFFF…FE. A second block offered at cycle 64 → accepted at 64, result at 128.
- Stub with random 3–20 cycle latency and spurious ls_ready in IDLE → result unchanged, no extra out_valid.
- reset_n pulsed low at cycle 30 of a block → all outputs at reset values and no out_valid. A following block completes correctly.
- Real LS-inverse unit with GOST decryption round keys from key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef and din=7f679d90bebc24305a468d42b9d4edcd → dout=1122334455667700ffeeddccbbaa9988.
